// File: rtl/cu_edge_data_read_arbiter.sv
// Round-robin arbiter for the shared edge-data-read command port. It applies per-requester
// outstanding-read credits, tags each command with its requester, and routes read data back.
module cu_edge_data_read_arbiter #(
    parameter int          NUM_REQ         = 2,
    parameter int          MAX_OUTSTANDING = 8,
    parameter logic [7:0]  CU_ID           = 8'hFB,
    parameter int          ADDR_W          = 64,
    parameter int          DATA_W          = 32,
    parameter int          IDX_W           = $clog2(NUM_REQ)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             cmd_out_valid,
    output logic [ADDR_W-1:0]                cmd_out_addr,
    output logic [7:0]                       cmd_out_tag,
    output logic [7:0]                       cmd_out_cu_id,
    input  logic                             cmd_out_ready,
    input  logic                             rsp_in_valid,
    input  logic [7:0]                       rsp_in_tag,
    input  logic [DATA_W-1:0]                rsp_in_data,
    output logic [NUM_REQ-1:0]               rsp_out_valid,
    output logic [DATA_W-1:0]                rsp_out_data,
    output logic                             tag_error,
    output logic                             idle
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_REQ-1:0][CW-1:0] credit_q, credit_d;
    logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic                       cmd_valid_q, cmd_valid_d;
    logic [ADDR_W-1:0]          cmd_addr_q, cmd_addr_d;
    logic [IDX_W-1:0]           cmd_tag_q, cmd_tag_d;
    logic [NUM_REQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]          rsp_data_q, rsp_data_d;
    logic                       tag_err_q, tag_err_d;
    logic                       idle_q, idle_d;

    logic [NUM_REQ-1:0]         eligible;
    logic                       can_load;
    logic                       grant_vld;
    logic [IDX_W-1:0]           grant_idx;
    logic [IDX_W-1:0]           cand;
    logic                       tag_ok;
    logic [IDX_W-1:0]           rsp_idx;

    always_comb begin
        can_load  = !cmd_valid_q || cmd_out_ready;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++)
            eligible[i] = req_valid[i] && (credit_q[i] < CW'(MAX_OUTSTANDING));
        // Scan farthest-first so the nearest eligible requester from rr_ptr wins last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = rr_ptr_q + IDX_W'(k);
            if (eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        grant_vld = grant_vld && can_load && !reset;
        req_ready = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_tag_d   = cmd_tag_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_vld) begin
            cmd_valid_d = 1'b1;
            cmd_addr_d  = req_addr[grant_idx];
            cmd_tag_d   = grant_idx;
            rr_ptr_d    = grant_idx + IDX_W'(1);
        end else if (can_load) begin
            cmd_valid_d = 1'b0;
        end

        tag_ok      = rsp_in_tag < 8'(NUM_REQ);
        rsp_idx     = rsp_in_tag[IDX_W-1:0];
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        tag_err_d   = tag_err_q || (rsp_in_valid && !tag_ok);
        if (rsp_in_valid && tag_ok) begin
            rsp_valid_d = NUM_REQ'(1) << rsp_idx;
            rsp_data_d  = rsp_in_data;
        end

        idle_d = !cmd_valid_d;
        for (int i = 0; i < NUM_REQ; i++) begin
            credit_d[i] = credit_q[i];
            // A grant and a return for the same requester cancel out.
            if ((grant_vld && grant_idx == IDX_W'(i)) &&
                !(rsp_in_valid && tag_ok && rsp_idx == IDX_W'(i)))
                credit_d[i] = credit_q[i] + CW'(1);
            else if (!(grant_vld && grant_idx == IDX_W'(i)) &&
                     (rsp_in_valid && tag_ok && rsp_idx == IDX_W'(i)) &&
                     credit_q[i] != '0)
                credit_d[i] = credit_q[i] - CW'(1);
            if (credit_d[i] != '0)
                idle_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            credit_q    <= '0;
            rr_ptr_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_tag_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            tag_err_q   <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            credit_q    <= credit_d;
            rr_ptr_q    <= rr_ptr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_tag_q   <= cmd_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            tag_err_q   <= tag_err_d;
            idle_q      <= idle_d;
        end
    end

    assign cmd_out_valid = cmd_valid_q;
    assign cmd_out_addr  = cmd_addr_q;
    assign cmd_out_tag   = {{(8 - IDX_W){1'b0}}, cmd_tag_q};
    assign cmd_out_cu_id = CU_ID;
    assign rsp_out_valid = rsp_valid_q;
    assign rsp_out_data  = rsp_data_q;
    assign tag_error     = tag_err_q;
    assign idle          = idle_q;

endmodule

// File: tb/tb_cu_edge_data_read_arbiter.sv
// Randomized bench for the edge-data-read arbiter; a cycle-level reference model built from
// the grant/credit/response rules predicts every output.
module tb_cu_edge_data_read_arbiter;
    localparam int NUM_REQ = 2;
    localparam int MAXO    = 8;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 32;

    logic                           clock = 1'b0;
    logic                           reset;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           cmd_out_valid;
    logic [ADDR_W-1:0]              cmd_out_addr;
    logic [7:0]                     cmd_out_tag;
    logic [7:0]                     cmd_out_cu_id;
    logic                           cmd_out_ready;
    logic                           rsp_in_valid;
    logic [7:0]                     rsp_in_tag;
    logic [DATA_W-1:0]              rsp_in_data;
    logic [NUM_REQ-1:0]             rsp_out_valid;
    logic [DATA_W-1:0]              rsp_out_data;
    logic                           tag_error;
    logic                           idle;

    cu_edge_data_read_arbiter #(
        .NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAXO), .CU_ID(8'hFB),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .cmd_out_valid(cmd_out_valid), .cmd_out_addr(cmd_out_addr),
        .cmd_out_tag(cmd_out_tag), .cmd_out_cu_id(cmd_out_cu_id),
        .cmd_out_ready(cmd_out_ready),
        .rsp_in_valid(rsp_in_valid), .rsp_in_tag(rsp_in_tag), .rsp_in_data(rsp_in_data),
        .rsp_out_valid(rsp_out_valid), .rsp_out_data(rsp_out_data),
        .tag_error(tag_error), .idle(idle)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit          m_valid;
    longint      m_addr;
    int          m_tag;
    int          m_rr;
    int          m_cred [NUM_REQ];
    int          m_rsp_vec;
    int unsigned m_rsp_data;
    bit          m_tag_err;
    int          n_grants;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (reset) return -1;
        if (m_valid && !cmd_out_ready) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j = (m_rr + k) % NUM_REQ;
            if (req_valid[j] && m_cred[j] < MAXO) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_addr = 0; m_tag = 0; m_rr = 0;
        m_rsp_vec = 0; m_rsp_data = 0; m_tag_err = 0;
        for (int i = 0; i < NUM_REQ; i++) m_cred[i] = 0;
    endtask

    task automatic step(input int p_req, input int p_rdy, input int p_rsp,
                        input int p_bad, input int p_rst);
        int g;
        int t;
        bit idle_exp;
        reset         = ($urandom_range(0, 99) < p_rst);
        cmd_out_ready = ($urandom_range(0, 99) < p_rdy);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = ($urandom_range(0, 99) < p_req);
            req_addr[i]  = {$urandom, $urandom};
        end
        rsp_in_valid = ($urandom_range(0, 99) < p_rsp);
        rsp_in_tag   = ($urandom_range(0, 99) < p_bad) ? 8'($urandom_range(NUM_REQ, 255))
                                                      : 8'($urandom_range(0, NUM_REQ - 1));
        rsp_in_data  = $urandom;
        #1;
        g = model_grant();
        chk("req_ready", 64'(req_ready), (g >= 0) ? 64'(1 << g) : 64'd0);
        if (req_ready !== 0 && (req_ready & ~req_valid) != 0)
            chk("ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            if (g >= 0) begin
                m_valid = 1; m_addr = req_addr[g]; m_tag = g;
                m_rr = (g + 1) % NUM_REQ; n_grants++;
            end else if (cmd_out_ready) begin
                m_valid = 0;
            end
            t = rsp_in_tag;
            m_rsp_vec = 0;
            if (rsp_in_valid) begin
                if (t < NUM_REQ) begin
                    m_rsp_vec = 1 << t; m_rsp_data = rsp_in_data;
                end else begin
                    m_tag_err = 1;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                bit inc = (g == i);
                bit dec = rsp_in_valid && t < NUM_REQ && t == i;
                if (inc && !dec) m_cred[i]++;
                else if (dec && !inc && m_cred[i] > 0) m_cred[i]--;
            end
        end
        #1;
        idle_exp = !m_valid;
        for (int i = 0; i < NUM_REQ; i++) if (m_cred[i] != 0) idle_exp = 0;
        chk("cmd_valid", 64'(cmd_out_valid), 64'(m_valid));
        if (m_valid) begin
            chk("cmd_addr", cmd_out_addr, m_addr);
            chk("cmd_tag", 64'(cmd_out_tag), 64'(m_tag));
        end
        chk("cu_id", 64'(cmd_out_cu_id), 64'hFB);
        chk("rsp_valid", 64'(rsp_out_valid), 64'(m_rsp_vec));
        if (m_rsp_vec != 0) chk("rsp_data", 64'(rsp_out_data), 64'(m_rsp_data));
        chk("tag_error", 64'(tag_error), 64'(m_tag_err));
        chk("idle", 64'(idle), 64'(idle_exp));
    endtask

    initial begin
        reset = 1; req_valid = '0; req_addr = '0; cmd_out_ready = 0;
        rsp_in_valid = 0; rsp_in_tag = 0; rsp_in_data = 0;
        model_reset();
        n_grants = 0;

        // reset, then an out-of-range tag sets the sticky error
        repeat (2) step(0, 100, 0, 0, 100);
        chk("reset_cmd_addr", cmd_out_addr, 64'd0);
        chk("reset_rsp_data", 64'(rsp_out_data), 64'd0);
        step(0, 100, 100, 100, 0);
        repeat (4) step(0, 100, 0, 0, 0);

        // fairness with full throughput
        step(0, 100, 0, 0, 100);
        repeat (200) step(100, 100, 40, 0, 0);

        // heavy backpressure
        repeat (300) step(70, 20, 30, 0, 0);

        // credit exhaustion with no returns, then a trickle of returns
        step(0, 100, 0, 0, 100);
        n_grants = 0;
        repeat (30) step(100, 100, 0, 0, 0);
        chk("credit_limit_grants", 64'(n_grants), 64'(NUM_REQ * MAXO));
        repeat (200) step(100, 100, 10, 0, 0);

        // mixed traffic with occasional mid-flight resets and bad tags
        repeat (2500) step(60, 70, 40, 3, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
